vector_exec_unit: RTL and testbench

VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

---
 rtl/vx_pkg.sv | 30 +++
 rtl/vx_lane_alu.sv | 39 +++
 rtl/vector_exec_unit.sv | 169 ++++++++++++++++
 tb/tb_vector_exec_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_pkg.sv
// -----------------------------------------------------------------------------
// vx_pkg
// Shared definitions for the vector execution unit and its scheduler:
//   vx_op_e     - lane operation opcodes (3-bit encoding used on cmd_op)
//   vx_state_e  - sequencing states of vector_exec_unit
// -----------------------------------------------------------------------------
package vx_pkg;

  localparam int VX_OP_W = 3;

  typedef enum logic [VX_OP_W-1:0] {
    VX_ADD = 3'd0,  // a + b, wraps
    VX_SUB = 3'd1,  // a - b, wraps
    VX_AND = 3'd2,
    VX_OR  = 3'd3,
    VX_XOR = 3'd4,
    VX_MUL = 3'd5,  // low DATA_WIDTH bits of a * b
    VX_MIN = 3'd6,  // signed minimum
    VX_MAX = 3'd7   // signed maximum
  } vx_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_EXEC,
    ST_WR
  } vx_state_e;

endpackage

// File: rtl/vx_lane_alu.sv
// -----------------------------------------------------------------------------
// vx_lane_alu
// Single-lane combinational ALU. All arithmetic wraps modulo 2^DATA_WIDTH;
// MIN/MAX treat operands as two's-complement.
// Ports:
//   op  in   vx_op_e          operation select
//   a   in   DATA_WIDTH       operand A
//   b   in   DATA_WIDTH       operand B
//   y   out  DATA_WIDTH       result
// -----------------------------------------------------------------------------
module vx_lane_alu
  import vx_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  vx_op_e                op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    y = '0;
    case (op)
      VX_ADD:  y = a + b;
      VX_SUB:  y = a - b;
      VX_AND:  y = a & b;
      VX_OR:   y = a | b;
      VX_XOR:  y = a ^ b;
      VX_MUL:  y = a * b;  // evaluated at DATA_WIDTH, keeps the low half
      VX_MIN:  y = ($signed(a) < $signed(b)) ? a : b;
      VX_MAX:  y = ($signed(a) > $signed(b)) ? a : b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_exec_unit.sv
// -----------------------------------------------------------------------------
// vector_exec_unit
// Executes one vector command at a time: reads source vreg A (and B unless a
// scalar is broadcast), applies the lane operation under a per-lane mask, and
// writes the result to the destination vreg.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake (ready only in IDLE)
//   cmd_op, cmd_vd, cmd_va, cmd_vb    operation and vreg indices
//   cmd_use_scalar, cmd_scalar        broadcast cmd_scalar as operand B
//   cmd_lane_mask                     lane enable; disabled lanes pass A through
//   vreg_rd_valid/idx/ready/data      register-file read port (data same cycle)
//   vreg_wr_valid/idx/data/ready      register-file write port
//   busy                              not idle
//   done                              one-cycle pulse on the write handshake
// -----------------------------------------------------------------------------
module vector_exec_unit
  import vx_pkg::*;
#(
  parameter int  LANES      = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_VREGS  = 32,
  localparam int IDX_W      = $clog2(NUM_VREGS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  vx_op_e                             cmd_op,
  input  logic [IDX_W-1:0]                   cmd_vd,
  input  logic [IDX_W-1:0]                   cmd_va,
  input  logic [IDX_W-1:0]                   cmd_vb,
  input  logic                               cmd_use_scalar,
  input  logic [DATA_WIDTH-1:0]              cmd_scalar,
  input  logic [LANES-1:0]                   cmd_lane_mask,
  output logic                               vreg_rd_valid,
  output logic [IDX_W-1:0]                   vreg_rd_idx,
  input  logic                               vreg_rd_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]   vreg_rd_data,
  output logic                               vreg_wr_valid,
  output logic [IDX_W-1:0]                   vreg_wr_idx,
  output logic [LANES-1:0][DATA_WIDTH-1:0]   vreg_wr_data,
  input  logic                               vreg_wr_ready,
  output logic                               busy,
  output logic                               done
);

  vx_state_e state_q, state_d;

  // Latched command
  vx_op_e                op_q;
  logic [IDX_W-1:0]      vd_q, va_q, vb_q;
  logic                  use_scalar_q;
  logic [DATA_WIDTH-1:0] scalar_q;
  logic [LANES-1:0]      mask_q;

  // Operand / result registers
  logic [LANES-1:0][DATA_WIDTH-1:0] a_q, b_q, result_q, alu_y;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: operand, command and result registers are deliberately not reset:
  // each is written before it is consumed, and the outputs derived from them
  // are forced to zero outside the states that use them.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_q         <= cmd_op;
          vd_q         <= cmd_vd;
          va_q         <= cmd_va;
          vb_q         <= cmd_vb;
          use_scalar_q <= cmd_use_scalar;
          scalar_q     <= cmd_scalar;
          mask_q       <= cmd_lane_mask;
        end
      end
      ST_RD_A: begin
        if (vreg_rd_ready) begin
          a_q <= vreg_rd_data;
          if (use_scalar_q) b_q <= {LANES{scalar_q}};
        end
      end
      ST_RD_B: begin
        if (vreg_rd_ready) b_q <= vreg_rd_data;
      end
      ST_EXEC: begin
        for (int i = 0; i < LANES; i++) begin
          result_q[i] <= mask_q[i] ? alu_y[i] : a_q[i];
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane ALUs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vx_lane_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .op (op_q),
      .a  (a_q[g]),
      .b  (b_q[g]),
      .y  (alu_y[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid)     state_d = ST_RD_A;
      ST_RD_A: if (vreg_rd_ready) state_d = use_scalar_q ? ST_EXEC : ST_RD_B;
      ST_RD_B: if (vreg_rd_ready) state_d = ST_EXEC;
      ST_EXEC:                    state_d = ST_WR;
      ST_WR:   if (vreg_wr_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Port requests are suppressed while rst is high so that a reset
  // landing in WR can never complete a write handshake on its way out.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    vreg_rd_valid = 1'b0;
    vreg_rd_idx   = '0;
    vreg_wr_valid = 1'b0;
    vreg_wr_idx   = '0;
    vreg_wr_data  = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_RD_A: begin
        vreg_rd_valid = !rst;
        vreg_rd_idx   = va_q;
      end
      ST_RD_B: begin
        vreg_rd_valid = !rst;
        vreg_rd_idx   = vb_q;
      end
      ST_WR: begin
        vreg_wr_valid = !rst;
        vreg_wr_idx   = vd_q;
        vreg_wr_data  = result_q;
      end
      default: ;
    endcase
    done = vreg_wr_valid && vreg_wr_ready;
  end

endmodule

// File: tb/tb_vector_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_vector_exec_unit
// Directed and randomized checks of vector_exec_unit against a lane-level
// reference model and a behavioural register file.
// -----------------------------------------------------------------------------
module tb_vector_exec_unit;
  import vx_pkg::*;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int NV    = 32;
  localparam int IW    = $clog2(NV);

  typedef logic [LANES-1:0][DW-1:0] vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  vx_op_e          cmd_op;
  logic [IW-1:0]   cmd_vd, cmd_va, cmd_vb;
  logic            cmd_use_scalar;
  logic [DW-1:0]   cmd_scalar;
  logic [LANES-1:0] cmd_lane_mask;
  logic            vreg_rd_valid;
  logic [IW-1:0]   vreg_rd_idx;
  logic            vreg_rd_ready;
  vec_t            vreg_rd_data;
  logic            vreg_wr_valid;
  logic [IW-1:0]   vreg_wr_idx;
  vec_t            vreg_wr_data;
  logic            vreg_wr_ready;
  logic            busy;
  logic            done;

  vec_t mem [NV];
  assign vreg_rd_data = mem[vreg_rd_idx];

  int n_checks = 0;
  int n_pass   = 0;
  bit both_valid_seen = 1'b0;

  always #5 clk = ~clk;

  always @(negedge clk) if (vreg_rd_valid && vreg_wr_valid) both_valid_seen = 1'b1;

  vector_exec_unit #(.LANES(LANES), .DATA_WIDTH(DW), .NUM_VREGS(NV)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_vd         (cmd_vd),
    .cmd_va         (cmd_va),
    .cmd_vb         (cmd_vb),
    .cmd_use_scalar (cmd_use_scalar),
    .cmd_scalar     (cmd_scalar),
    .cmd_lane_mask  (cmd_lane_mask),
    .vreg_rd_valid  (vreg_rd_valid),
    .vreg_rd_idx    (vreg_rd_idx),
    .vreg_rd_ready  (vreg_rd_ready),
    .vreg_rd_data   (vreg_rd_data),
    .vreg_wr_valid  (vreg_wr_valid),
    .vreg_wr_idx    (vreg_wr_idx),
    .vreg_wr_data   (vreg_wr_data),
    .vreg_wr_ready  (vreg_wr_ready),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Lane reference: plain arithmetic on unsigned / signed integers.
  function automatic logic [DW-1:0] ref_op(input vx_op_e op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned m  = 64'd1 << DW;
    int sa = signed'(a);
    int sb = signed'(b);
    case (op)
      VX_ADD: return DW'((ua + ub) % m);
      VX_SUB: return DW'((ua + m - ub) % m);
      VX_AND: return a & b;
      VX_OR:  return a | b;
      VX_XOR: return a ^ b;
      VX_MUL: return DW'((ua * ub) % m);
      VX_MIN: return (sa <= sb) ? a : b;
      VX_MAX: return (sa >= sb) ? a : b;
      default: return '0;
    endcase
  endfunction

  // Issues one command at a negedge with cmd_ready expected, services the
  // register-file ports (stalling the first read rd_stall cycles and the write
  // wr_stall cycles) and checks the outcome against the model.
  task automatic run_cmd(input string tag, input vx_op_e op, input logic [IW-1:0] vd,
                         input logic [IW-1:0] va, input logic [IW-1:0] vb, input bit us,
                         input logic [DW-1:0] sc, input logic [LANES-1:0] mask,
                         input int rd_stall, input int wr_stall, output vec_t got);
    vec_t a, b, exp, held_data;
    logic [IW-1:0] held_idx, held_widx, got_idx;
    int reads = 0, writes = 0, lat = -1, rd_left = rd_stall, wr_left = wr_stall;
    bit rd_hold = 0, wr_hold = 0, stable = 1, done_seen = 0, done_ok = 1;
    got = 'x;
    got_idx = 'x;
    a = mem[va];
    b = us ? {LANES{sc}} : mem[vb];
    for (int i = 0; i < LANES; i++) exp[i] = mask[i] ? ref_op(op, a[i], b[i]) : a[i];

    check({tag, "/cmd_ready"}, cmd_ready, 1);
    cmd_op = op; cmd_vd = vd; cmd_va = va; cmd_vb = vb;
    cmd_use_scalar = us; cmd_scalar = sc; cmd_lane_mask = mask;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;

    for (int k = 1; k <= 80 && !done_seen; k++) begin
      if (rd_hold && (!vreg_rd_valid || vreg_rd_idx !== held_idx)) stable = 0;
      if (wr_hold && (!vreg_wr_valid || vreg_wr_idx !== held_widx ||
                      vreg_wr_data !== held_data)) stable = 0;
      vreg_rd_ready = 1'b1;
      vreg_wr_ready = 1'b1;
      if (vreg_rd_valid) begin
        if (reads == 0 && rd_left > 0) begin
          vreg_rd_ready = 1'b0;
          rd_left--;
          if (!rd_hold) begin rd_hold = 1; held_idx = vreg_rd_idx; end
        end else begin
          reads++;
          rd_hold = 0;
        end
      end
      if (vreg_wr_valid) begin
        if (wr_left > 0) begin
          vreg_wr_ready = 1'b0;
          wr_left--;
          if (!wr_hold) begin wr_hold = 1; held_widx = vreg_wr_idx; held_data = vreg_wr_data; end
        end else begin
          writes++;
          wr_hold = 0;
          got = vreg_wr_data;
          got_idx = vreg_wr_idx;
        end
      end
      #1;
      if (done !== (vreg_wr_valid && vreg_wr_ready)) done_ok = 0;
      if (done === 1'b1) begin done_seen = 1; lat = k; end
      @(negedge clk);
    end
    vreg_rd_ready = 1'b1;
    vreg_wr_ready = 1'b1;

    check({tag, "/done_seen"}, done_seen, 1);
    check({tag, "/latency"}, lat, (us ? 3 : 4) + rd_stall + wr_stall);
    check({tag, "/reads"}, reads, us ? 1 : 2);
    check({tag, "/writes"}, writes, 1);
    check({tag, "/wr_idx"}, got_idx, vd);
    check({tag, "/wr_data"}, got, exp);
    check({tag, "/stable"}, stable, 1);
    check({tag, "/done_pulse"}, done_ok, 1);
    check({tag, "/idle_after"}, {busy, done, cmd_ready}, 3'b001);
    mem[vd] = exp;
  endtask

  initial begin
    vec_t got;
    bit seen;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = VX_ADD; cmd_vd = '0; cmd_va = '0; cmd_vb = '0;
    cmd_use_scalar = 1'b0; cmd_scalar = '0; cmd_lane_mask = '0;
    vreg_rd_ready = 1'b1;
    vreg_wr_ready = 1'b1;
    for (int i = 0; i < NV; i++)
      for (int l = 0; l < LANES; l++) mem[i][l] = $urandom;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset/outputs", {busy, done, vreg_rd_valid, vreg_wr_valid, cmd_ready}, 5'b00001);
    check("reset/idx", {vreg_rd_idx, vreg_wr_idx}, '0);
    check("reset/wr_data", vreg_wr_data, '0);

    // ADD, all lanes, always ready
    mem[1] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem[2] = {32'd40, 32'd30, 32'd20, 32'd10};
    run_cmd("add", VX_ADD, 5'd3, 5'd1, 5'd2, 0, '0, 4'b1111, 0, 0, got);
    check("add/const", got, {32'd44, 32'd33, 32'd22, 32'd11});

    // SUB wrap, MIN/MAX signed
    mem[4] = '0;
    mem[5] = {LANES{32'd1}};
    run_cmd("sub", VX_SUB, 5'd6, 5'd4, 5'd5, 0, '0, 4'b1111, 0, 0, got);
    check("sub/const", got, {LANES{32'hFFFF_FFFF}});
    mem[7] = {LANES{32'hFFFF_FFFF}};
    run_cmd("min", VX_MIN, 5'd8, 5'd7, 5'd5, 0, '0, 4'b1111, 0, 0, got);
    check("min/const", got, {LANES{32'hFFFF_FFFF}});
    run_cmd("max", VX_MAX, 5'd9, 5'd7, 5'd5, 0, '0, 4'b1111, 0, 0, got);
    check("max/const", got, {LANES{32'd1}});

    // MUL with scalar broadcast and partial mask
    mem[10] = {32'd8, 32'd7, 32'd6, 32'd5};
    run_cmd("mul_sc", VX_MUL, 5'd11, 5'd10, 5'd31, 1, 32'd3, 4'b0101, 0, 0, got);
    check("mul_sc/const", got, {32'd8, 32'd21, 32'd6, 32'd15});

    // Back-pressure on first read and on write
    run_cmd("stall", VX_XOR, 5'd12, 5'd1, 5'd2, 0, '0, 4'b1111, 3, 2, got);

    // Aliased registers: va == vb == vd
    run_cmd("alias", VX_ADD, 5'd13, 5'd13, 5'd13, 0, '0, 4'b1011, 0, 0, got);

    // Reset while parked in WR with write back-pressure
    cmd_op = VX_ADD; cmd_vd = 5'd14; cmd_va = 5'd1; cmd_vb = 5'd2;
    cmd_use_scalar = 1'b0; cmd_lane_mask = 4'b1111;
    vreg_wr_ready = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (vreg_wr_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    check("rst_wr/reached_wr", seen, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wr/no_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_wr/after", {busy, done, vreg_wr_valid, vreg_rd_valid, cmd_ready}, 5'b00001);
    check("rst_wr/after_wr", {vreg_wr_idx, vreg_wr_data}, '0);
    vreg_wr_ready = 1'b1;
    @(negedge clk);
    run_cmd("post_rst", VX_ADD, 5'd15, 5'd1, 5'd2, 0, '0, 4'b1111, 0, 0, got);
    check("post_rst/const", got, {32'd44, 32'd33, 32'd22, 32'd11});

    // Randomized commands
    for (int n = 0; n < 20; n++) begin
      run_cmd($sformatf("rnd%0d", n), vx_op_e'($urandom_range(0, 7)),
              IW'($urandom_range(0, NV - 1)), IW'($urandom_range(0, NV - 1)),
              IW'($urandom_range(0, NV - 1)), bit'($urandom_range(0, 1)), $urandom,
              LANES'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), got);
    end

    check("rd_wr_exclusive", both_valid_seen, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
